video_line_fetch_sched: RTL

VIDEO_LINE_FETCH_SCHED -- requirements
Module: video_line_fetch_sched

---
 rtl/video_line_fetch_sched_pkg.sv | 20 ++
 rtl/video_line_fetch_sched_edge_det.sv | 35 +++
 rtl/video_line_fetch_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/video_line_fetch_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : video_line_fetch_sched_pkg
// Brief    : Shared video types: fetch FSM state encoding and line-index width.
// Revision : 1.0 - initial release
// ============================================================================
package video_line_fetch_sched_pkg;

    localparam int unsigned c_LINE_IDX_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/video_line_fetch_sched_edge_det.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : video_edge_det
// Brief    : Registered-compare edge detector reporting transitions into and
//            out of a configurable active level.
// Revision : 1.0 - initial release
// ============================================================================
module video_edge_det #(
    parameter logic ACTIVE_LEVEL = 1'b1
) (
    input  logic pixel_clk,
    input  logic sys_rst_n,
    input  logic sig,
    output logic to_active,
    output logic to_inactive
);

    logic r_prev;

    // Reset to the active level so a signal already active at reset release
    // is not reported as a fresh edge.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_prev <= ACTIVE_LEVEL;
        end else begin
            r_prev <= sig;
        end
    end

    assign to_active   = (sig == ACTIVE_LEVEL) && (r_prev != ACTIVE_LEVEL);
    assign to_inactive = (sig != ACTIVE_LEVEL) && (r_prev == ACTIVE_LEVEL);

endmodule
`default_nettype wire

// File: rtl/video_line_fetch_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : video_line_fetch_sched
// Brief    : Schedules line reads into a small line buffer ahead of display,
//            tracking filled slots and flagging underruns per frame.
//            Optional macro LINE_FETCH_STATS_EN adds a saturating underrun_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module video_line_fetch_sched
    import video_line_fetch_sched_pkg::*;
#(
    parameter logic [c_LINE_IDX_W-1:0] V_VALID        = 12'd1080,
    parameter int unsigned             LINE_BUF_DEPTH = 2,
    parameter logic                    VS_Polarity    = 1'b0
) (
    input  logic                    pixel_clk,
    input  logic                    sys_rst_n,
    input  logic                    video_vs,
    input  logic                    video_de,
    output logic                    rd_req,
    output logic [c_LINE_IDX_W-1:0] rd_line,
    input  logic                    rd_ack,
    input  logic                    rd_done,
    output logic                    frame_start,
    output logic [2:0]              lines_ready,
    output logic                    underrun
`ifdef LINE_FETCH_STATS_EN
    ,
    output logic [15:0]             underrun_cnt
`endif
);

    localparam logic [2:0] c_DEPTH = 3'(LINE_BUF_DEPTH);

    fetch_state_t              r_state;
    fetch_state_t              w_next_state;
    logic [c_LINE_IDX_W-1:0]   r_issue_line;
    logic [c_LINE_IDX_W-1:0]   w_issue_line_nxt;
    logic [2:0]                r_lines_ready;
    logic [2:0]                w_lines_ready_nxt;
    logic                      r_underrun;
    logic                      r_flush_pending;
    logic                      r_frame_start;

    logic w_sync;
    logic w_de_rise;
    logic w_de_fall;
    logic w_done_ok;
    logic w_flush_done;
    logic w_line_done;
    logic w_restart;
    logic w_clear;
    logic w_issue_ok;
    logic w_underrun_evt;

    video_edge_det #(
        .ACTIVE_LEVEL (VS_Polarity)
    ) u_vs_edge (
        .pixel_clk   (pixel_clk),
        .sys_rst_n   (sys_rst_n),
        .sig         (video_vs),
        .to_active   (w_sync),
        .to_inactive ()
    );

    video_edge_det #(
        .ACTIVE_LEVEL (1'b1)
    ) u_de_edge (
        .pixel_clk   (pixel_clk),
        .sys_rst_n   (sys_rst_n),
        .sig         (video_de),
        .to_active   (w_de_rise),
        .to_inactive (w_de_fall)
    );

    // A sync arriving together with the completion is treated like a pending
    // flush: the returned line belongs to the old frame.
    assign w_done_ok      = (r_state == ST_WAIT) && rd_done;
    assign w_flush_done   = w_done_ok && (r_flush_pending || w_sync);
    assign w_line_done    = w_done_ok && !w_flush_done;
    assign w_restart      = w_sync && ((r_state == ST_IDLE) || (r_state == ST_HOLD));
    assign w_clear        = w_restart || w_flush_done;
    assign w_underrun_evt = w_de_rise && (r_lines_ready == 3'd0);

    always_comb begin
        w_lines_ready_nxt = r_lines_ready;
        if (w_clear) begin
            w_lines_ready_nxt = 3'd0;
        end else if (w_line_done && !w_de_fall) begin
            w_lines_ready_nxt = r_lines_ready + 3'd1;
        end else if (!w_line_done && w_de_fall && (r_lines_ready != 3'd0)) begin
            w_lines_ready_nxt = r_lines_ready - 3'd1;
        end
    end

    always_comb begin
        w_issue_line_nxt = r_issue_line;
        if (w_clear) begin
            w_issue_line_nxt = '0;
        end else if (w_line_done) begin
            w_issue_line_nxt = r_issue_line + 1'b1;
        end
    end

    // Evaluated on post-update counters so the FSM decides on the values it
    // will hold in the next cycle.
    assign w_issue_ok = (w_issue_line_nxt < V_VALID) && (w_lines_ready_nxt < c_DEPTH);

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sync) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rd_ack) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_flush_done) begin
                    w_next_state = ST_ISSUE;
                end else if (w_line_done) begin
                    w_next_state = w_issue_ok ? ST_ISSUE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_sync || w_issue_ok) w_next_state = ST_ISSUE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_req  = (r_state == ST_ISSUE);
        rd_line = r_issue_line;
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_issue_line    <= '0;
            r_lines_ready   <= 3'd0;
            r_underrun      <= 1'b0;
            r_flush_pending <= 1'b0;
            r_frame_start   <= 1'b0;
        end else begin
            r_issue_line  <= w_issue_line_nxt;
            r_lines_ready <= w_lines_ready_nxt;
            r_frame_start <= w_sync;

            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end else if (w_sync) begin
                r_underrun <= 1'b0;
            end

            if (w_flush_done) begin
                r_flush_pending <= 1'b0;
            end else if (w_sync && ((r_state == ST_ISSUE) || (r_state == ST_WAIT))) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

    assign frame_start = r_frame_start;
    assign lines_ready = r_lines_ready;
    assign underrun    = r_underrun;

`ifdef LINE_FETCH_STATS_EN
    logic [15:0] r_underrun_cnt;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_underrun_cnt <= 16'd0;
        end else if (w_underrun_evt && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
`default_nettype wire
